// File: rtl/dm_responder.sv
// dm_responder: fixed-latency data-memory responder with valid/ready request and response handshakes.
module dm_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic [1:0] width_q, width_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] word, ld_data, wr_word;
  logic [15:0] half;
  logic [7:0] byt;
  logic [4:0] sh;
  logic acc, err;
  assign idx     = addr_q[ADDR_WIDTH+1:2];
  assign word    = mem[idx];
  assign sh      = {addr_q[1:0], 3'b000};
  assign byt     = 8'(word >> sh);
  assign half    = addr_q[1] ? word[31:16] : word[15:0];
  assign err     = width_q == 2'b11 || (width_q == 2'b00 && addr_q[1:0] != 2'b00) ||
                   (width_q == 2'b01 && addr_q[0]) || (addr_q >> (ADDR_WIDTH + 2)) != 32'd0;
  assign ld_data = width_q == 2'b00 ? word :
                   width_q == 2'b01 ? {{16{sign_q & half[15]}}, half} : {{24{sign_q & byt[7]}}, byt};
  // Sub-word stores merge the new lane into the current word.
  assign wr_word = width_q == 2'b00 ? wdata_q :
                   width_q == 2'b01 ? (addr_q[1] ? {wdata_q[15:0], word[15:0]} : {word[31:16], wdata_q[15:0]}) :
                   (word & ~(32'hff << sh)) | ({24'd0, wdata_q[7:0]} << sh);
  assign acc     = state_q == BUSY && cnt_q == '0;
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sign_d  = sign_q;
    width_d = width_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        sign_d  = req_sign;
        width_d = req_width;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        cnt_d   = CW'(LATENCY - 1);
        state_d = BUSY;
      end
      BUSY: if (acc) begin
        rdata_d = (err || we_q) ? 32'd0 : ld_data;
        err_d   = err;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      width_q <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sign_q  <= sign_d;
      width_q <= width_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    end else if (acc && !err && we_q) begin
      mem[idx] <= wr_word;
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized and directed checks of dm_responder against a byte-addressed memory model.
module tb_dm_responder;
  localparam int AW  = 12;
  localparam int LAT = 3;
  localparam int NB  = 4 << AW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0, resp_ready = 1'b0;
  logic [1:0] req_width = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0] bm [NB];
  int n_chk = 0, n_pass = 0;

  dm_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_width(req_width), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) bm[i] = 8'd0;
  endtask

  // Reference: memory as a flat byte array, accesses as n little-endian bytes.
  task automatic model(input logic we, input logic [1:0] w, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int n;
    n  = w == 2'd0 ? 4 : w == 2'd1 ? 2 : 1;
    e  = w == 2'd3 || (a % n) != 0 || a >= NB;
    rd = 32'd0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < n; i++) bm[int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = bm[int'(a) + i];
        if (sg && n < 4 && rd[8*n-1]) for (int i = 8*n; i < 32; i++) rd[i] = 1'b1;
      end
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] w, input logic sg, input logic [31:0] a,
                     input logic [31:0] wd, input int hold);
    logic [31:0] er, held;
    logic ee;
    int lat;
    model(we, w, sg, a, wd, er, ee);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_width = w; req_sign = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_width = 2'($urandom); req_sign = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, LAT);
    chk("rdata", resp_rdata, er);
    chk("err", {31'd0, resp_err}, {31'd0, ee});
    held = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      req_valid = $urandom;
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_rdata", resp_rdata, held);
    end
    req_valid = hold > 0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid = 1'b0;
    chk("hs_valid", {31'd0, resp_valid}, 32'd0);
    chk("hs_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0] w;
    clear_model();
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b1;
    txn(1, 2'd0, 0, 32'h10, 32'h12345678, 0);
    txn(0, 2'd0, 0, 32'h10, 32'h0, 0);
    txn(1, 2'd2, 0, 32'h13, 32'h00000080, 0);
    txn(0, 2'd2, 1, 32'h13, 32'h0, 0);
    txn(0, 2'd2, 0, 32'h13, 32'h0, 0);
    txn(0, 2'd0, 0, 32'h10, 32'h0, 0);
    txn(0, 2'd1, 1, 32'h12, 32'h0, 0);
    txn(1, 2'd0, 0, 32'h20, 32'hCAFEF00D, 0);
    txn(1, 2'd0, 0, 32'h22, 32'h11111111, 0);
    txn(0, 2'd0, 0, 32'h20, 32'h0, 0);
    txn(0, 2'd1, 0, 32'h21, 32'h0, 0);
    txn(0, 2'd3, 0, 32'h20, 32'h0, 0);
    txn(1, 2'd0, 0, 32'h4000, 32'hFFFFFFFF, 0);
    txn(0, 2'd0, 0, 32'h0, 32'h0, 0);
    txn(0, 2'd0, 0, 32'h3FFC, 32'h0, 0);
    txn(0, 2'd0, 0, 32'h10, 32'h0, 5);
    for (int t = 0; t < 200; t++) begin
      w = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 9) == 0 ? $urandom : ($urandom_range(0, 9) == 0 ? 32'h3FF0 + $urandom_range(0, 15) : $urandom_range(0, 63));
      txn($urandom, w, $urandom, a, $urandom, $urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
    end
    txn(1, 2'd0, 0, 32'h40, 32'hDEADBEEF, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = 2'd0; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_busy");
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    txn(0, 2'd0, 0, 32'h40, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = 2'd0; req_addr = 32'h44; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("rst_acc");
    @(negedge clk);
    reset = 1'b1;
    txn(0, 2'd0, 0, 32'h44, 32'h0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
